// File: rtl/sumador_one_bit.sv
// One-bit full adder: {Co,So} = A + B + Ci, with optional output register.
// Latency: 1 cycle when REGISTERED=1, 0 cycles (pure combinational) when REGISTERED=0.
// Backpressure: none; a new vector is accepted every cycle and a result is never stalled.
//
// Ports:
//   clk       - single clock, rising-edge (unused when REGISTERED=0)
//   rst       - synchronous active-high reset (unused when REGISTERED=0)
//   A, B      - addend bits
//   Ci        - carry-in
//   Co        - carry-out
//   So        - sum bit
//   out_valid - Co/So hold a result computed from inputs sampled after reset release
module sumador_one_bit #(
    parameter bit REGISTERED = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic Co,
    output logic So,
    output logic out_valid
);

    // Shared half-sum term: used both for the sum and for carry propagation.
    logic half_sum;
    logic sum_comb;
    logic carry_comb;

    assign half_sum   = A ^ B;
    assign sum_comb   = half_sum ^ Ci;
    // Carry is generated by A&B, or propagated from Ci when exactly one addend is set.
    assign carry_comb = (A & B) | (Ci & half_sum);

    generate
        if (REGISTERED) begin : g_reg
            logic co_q;
            logic so_q;
            logic vld_q;

            // Reset wins over data sampled on the same edge, so an in-flight
            // result is discarded and the first valid output after reset comes
            // from the first edge where rst is low.
            always_ff @(posedge clk) begin
                if (rst) begin
                    co_q  <= 1'b0;
                    so_q  <= 1'b0;
                    vld_q <= 1'b0;
                end else begin
                    co_q  <= carry_comb;
                    so_q  <= sum_comb;
                    vld_q <= 1'b1;
                end
            end

            assign Co        = co_q;
            assign So        = so_q;
            assign out_valid = vld_q;
        end else begin : g_comb
            // Clock and reset play no part in this variant; fold them into a
            // sink so they are visibly intentional leftovers of the port list.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;

            assign Co        = carry_comb;
            assign So        = sum_comb;
            assign out_valid = 1'b1;
        end
    endgenerate

endmodule

// File: tb/tb_sumador_one_bit.sv
// Directed bench for sumador_one_bit: registered and combinational variants side by side.
module tb_sumador_one_bit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0, b = 1'b0, ci = 1'b0;
    logic co, so, ov;

    // Combinational instance: its clock never toggles.
    logic clk_idle = 1'b0;
    logic rst_idle = 1'b0;
    logic a0 = 1'b0, b0 = 1'b0, ci0 = 1'b0;
    logic co0, so0, ov0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sumador_one_bit #(.REGISTERED(1'b1)) dut_reg (
        .clk(clk), .rst(rst), .A(a), .B(b), .Ci(ci),
        .Co(co), .So(so), .out_valid(ov)
    );

    sumador_one_bit #(.REGISTERED(1'b0)) dut_comb (
        .clk(clk_idle), .rst(rst_idle), .A(a0), .B(b0), .Ci(ci0),
        .Co(co0), .So(so0), .out_valid(ov0)
    );

    // {out_valid, Co, So} expected for a valid result of a+b+ci.
    function automatic logic [2:0] exp_sum(input logic x, input logic y, input logic z);
        int s;
        s = int'(x) + int'(y) + int'(z);
        return {1'b1, s[1:0]};
    endfunction

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed {ov,co,so}=%b expected %b", tag, obs, exp);
        end
    endtask

    // Drive registered-DUT inputs, then advance one rising edge and settle.
    task automatic cyc(input logic ai, input logic bi, input logic cii, input logic ri);
        a = ai; b = bi; ci = cii; rst = ri;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] tv [8];
        logic [1:0] tbl [8];
        logic [2:0] r;
        logic [2:0] held;

        // {A,B,Ci} stepping order and hand-computed {Co,So}.
        tv[0] = 3'b000; tbl[0] = 2'b00;
        tv[1] = 3'b100; tbl[1] = 2'b01;
        tv[2] = 3'b010; tbl[2] = 2'b01;
        tv[3] = 3'b110; tbl[3] = 2'b10;
        tv[4] = 3'b001; tbl[4] = 2'b01;
        tv[5] = 3'b101; tbl[5] = 2'b10;
        tv[6] = 3'b011; tbl[6] = 2'b10;
        tv[7] = 3'b111; tbl[7] = 2'b11;

        // Reset held for two edges with all inputs high.
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check("reset_edge1", {ov, co, so}, 3'b000);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check("reset_edge2", {ov, co, so}, 3'b000);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        check("reset_release", {ov, co, so}, 3'b111);

        // Exhaustive truth table, one cycle latency.
        for (int i = 0; i < 8; i++) begin
            cyc(tv[i][2], tv[i][1], tv[i][0], 1'b0);
            check($sformatf("table_reg_%b", tv[i]), {ov, co, so}, {1'b1, tbl[i]});
        end

        // Hold: input glitches between edges must not reach the outputs.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("hold_base", {ov, co, so}, 3'b110);
        #2; a = 1'b0; b = 1'b0; ci = 1'b1;
        #1; check("hold_glitch1", {ov, co, so}, 3'b110);
        #2; a = 1'b1; b = 1'b0; ci = 1'b1;
        #1; check("hold_glitch2", {ov, co, so}, 3'b110);
        @(posedge clk); #1;
        check("hold_next_edge", {ov, co, so}, 3'b110);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("hold_after", {ov, co, so}, 3'b100);

        // Mid-stream reset: one reset edge, then stream resumes.
        for (int i = 0; i < 24; i++) begin
            r = 3'($urandom);
            if (i == 10) begin
                cyc(r[2], r[1], r[0], 1'b1);
                check("midreset_cycle", {ov, co, so}, 3'b000);
            end else begin
                cyc(r[2], r[1], r[0], 1'b0);
                check($sformatf("midreset_stream_%0d", i), {ov, co, so}, exp_sum(r[2], r[1], r[0]));
            end
        end

        // Random scoreboard on the registered variant.
        for (int i = 0; i < 1000; i++) begin
            r = 3'($urandom);
            cyc(r[2], r[1], r[0], 1'b0);
            check("random_reg", {ov, co, so}, exp_sum(r[2], r[1], r[0]));
        end

        // Combinational variant: clock idle, check after settling.
        for (int i = 0; i < 8; i++) begin
            a0 = tv[i][2]; b0 = tv[i][1]; ci0 = tv[i][0];
            #2;
            check($sformatf("table_comb_%b", tv[i]), {ov0, co0, so0}, {1'b1, tbl[i]});
        end
        // Reset has no effect on the combinational variant.
        rst_idle = 1'b1;
        a0 = 1'b1; b0 = 1'b0; ci0 = 1'b1;
        #2;
        check("comb_ignores_rst", {ov0, co0, so0}, 3'b110);
        rst_idle = 1'b0;
        for (int i = 0; i < 200; i++) begin
            held = 3'($urandom);
            a0 = held[2]; b0 = held[1]; ci0 = held[0];
            #2;
            check("random_comb", {ov0, co0, so0}, exp_sum(held[2], held[1], held[0]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
